// File: rtl/video_pkg.sv
// Shared 640x480@60 raster constants for the video path (vga_timing, display).
// Each stage takes its geometry from here, so all of them agree on one timing.
package video_pkg;

    localparam int COORD_W     = 11;

    localparam int DEF_CLK_DIV = 2;

    localparam int H_ACTIVE_640 = 640;
    localparam int H_FRONT_640  = 16;
    localparam int H_SYNC_640   = 96;
    localparam int H_BACK_640   = 48;
    localparam int H_BLANK      = H_FRONT_640 + H_SYNC_640 + H_BACK_640;
    localparam int H_TOTAL      = H_ACTIVE_640 + H_BLANK;

    localparam int V_ACTIVE_480 = 480;
    localparam int V_FRONT_480  = 10;
    localparam int V_SYNC_480   = 2;
    localparam int V_BACK_480   = 33;
    localparam int V_TOTAL      = V_ACTIVE_480 + V_FRONT_480 + V_SYNC_480 + V_BACK_480;

    typedef logic [COORD_W-1:0] coord_t;

    // The divider needs at least one bit, even when it divides by one.
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Counter that runs START..LAST and then returns to START, advancing on inc.
// It exposes the value it will take at the next edge, so callers can register logic aligned with it.
module wrap_counter #(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  START = '0,
    parameter logic [WIDTH-1:0]  LAST  = '1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    always_comb begin
        wrap       = inc && (count == LAST);
        count_next = count;
        if (inc) begin
            count_next = wrap ? START : count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            count <= START;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 raster generator: pixel divider, signed h / unsigned v beam position,
// pixel enable, line strobe, and sync levels for the connector.
module vga_timing
    import video_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = H_ACTIVE_640,
    parameter int H_FRONT  = H_FRONT_640,
    parameter int H_SYNC   = H_SYNC_640,
    parameter int H_BACK   = H_BACK_640,
    parameter int V_ACTIVE = V_ACTIVE_480,
    parameter int V_FRONT  = V_FRONT_480,
    parameter int V_SYNC   = V_SYNC_480,
    parameter int V_BACK   = V_BACK_480
) (
    input  logic               clk,
    input  logic               res,
    output logic               enable_pixel,
    output logic [COORD_W-1:0] h_pixel,
    output logic [COORD_W-1:0] v_pixel,
    output logic               hsync,
    output logic               vsync,
    output logic               vga_hs_n,
    output logic               vga_vs_n
);

    localparam int HBL   = H_FRONT + H_SYNC + H_BACK;
    localparam int VTOT  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W = div_width(CLK_DIV);

    localparam logic [DIV_W-1:0]          DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0]        H_FIRST  = COORD_W'(-HBL);
    localparam logic [COORD_W-1:0]        H_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic signed [COORD_W-1:0] HS_ON    = COORD_W'(H_FRONT - HBL);
    localparam logic signed [COORD_W-1:0] HS_OFF   = COORD_W'(H_FRONT + H_SYNC - HBL);
    localparam logic [COORD_W-1:0]        V_LAST   = COORD_W'(VTOT - 1);
    localparam logic [COORD_W-1:0]        V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0]        VS_ON    = COORD_W'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_W-1:0]        VS_OFF   = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic                      tick;
    logic                      h_wrap;
    logic                      v_wrap_unused;
    logic [DIV_W-1:0]          div_count_unused;
    logic [DIV_W-1:0]          div_next_unused;
    logic signed [COORD_W-1:0] h_next;
    logic [COORD_W-1:0]        v_next;
    logic                      in_hs;
    logic                      in_vs;
    logic                      active_next;

    wrap_counter #(.WIDTH(DIV_W), .START('0), .LAST(DIV_LAST)) u_div (
        .clk        (clk),
        .res        (res),
        .inc        (1'b1),
        .count      (div_count_unused),
        .count_next (div_next_unused),
        .wrap       (tick)
    );

    // Blanking sits at negative h so the active region starts at 0 and
    // h_pixel[10] alone marks blanking for the display stage.
    wrap_counter #(.WIDTH(COORD_W), .START(H_FIRST), .LAST(H_LAST)) u_h (
        .clk        (clk),
        .res        (res),
        .inc        (tick),
        .count      (h_pixel),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    wrap_counter #(.WIDTH(COORD_W), .START('0), .LAST(V_LAST)) u_v (
        .clk        (clk),
        .res        (res),
        .inc        (h_wrap),
        .count      (v_pixel),
        .count_next (v_next),
        .wrap       (v_wrap_unused)
    );

    // Decode from the upcoming position so these registers line up with the coordinates.
    always_comb begin
        in_hs       = (h_next >= HS_ON) && (h_next < HS_OFF);
        in_vs       = (v_next >= VS_ON) && (v_next < VS_OFF);
        active_next = !h_next[COORD_W-1] && (v_next < V_ACT);
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            enable_pixel <= 1'b0;
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            vga_hs_n     <= 1'b1;
            vga_vs_n     <= 1'b1;
        end else begin
            enable_pixel <= tick && active_next;
            hsync        <= h_wrap;
            vsync        <= in_vs;
            vga_hs_n     <= !in_hs;
            vga_vs_n     <= !in_vs;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a CLK_DIV=2 and a CLK_DIV=1 instance run against an arithmetic raster model.
// The vertical geometry is shortened (10 lines per frame) so that whole frames fit in a short run.
module tb_vga_timing;

    localparam int VA = 4;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VT = VA + VF + VS + VB;

    typedef logic [26:0] snap_t;

    logic clk = 1'b0;
    logic res = 1'b0;

    logic        en_a, hsync_a, vsync_a, hs_n_a, vs_n_a;
    logic [10:0] h_a, v_a;
    logic        en_b, hsync_b, vsync_b, hs_n_b, vs_n_b;
    logic [10:0] h_b, v_b;

    int errors = 0;
    int checks = 0;
    int n_clk  = 0;

    snap_t q_a[$];
    snap_t q_b[$];

    always #5 clk = ~clk;

    vga_timing #(.CLK_DIV(2), .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut_a (
        .clk(clk), .res(res), .enable_pixel(en_a), .h_pixel(h_a), .v_pixel(v_a),
        .hsync(hsync_a), .vsync(vsync_a), .vga_hs_n(hs_n_a), .vga_vs_n(vs_n_a)
    );

    vga_timing #(.CLK_DIV(1), .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut_b (
        .clk(clk), .res(res), .enable_pixel(en_b), .h_pixel(h_b), .v_pixel(v_b),
        .hsync(hsync_b), .vsync(vsync_b), .vga_hs_n(hs_n_b), .vga_vs_n(vs_n_b)
    );

    // Expected outputs after n clocks out of reset, from plain division of elapsed time.
    function automatic snap_t model(input int n, input int d);
        int ticks, p, h, v;
        logic tk, en, hs, hsn, vsn;
        ticks = n / d;
        p     = ticks % (800 * VT);
        h     = (p % 800) - 160;
        v     = p / 800;
        tk    = (n > 0) && ((n % d) == 0);
        en    = tk && (h >= 0) && (v < VA);
        hs    = tk && (h == -160);
        hsn   = !((h >= -144) && (h < -48));
        vsn   = !((v >= VA + VF) && (v < VA + VF + VS));
        return {en, 11'(h), 11'(v), hs, !vsn, hsn, vsn};
    endfunction

    always @(posedge clk) begin
        if (!res) n_clk = 0;
        else      n_clk = n_clk + 1;
        q_a.push_back(model(n_clk, 2));
        q_b.push_back(model(n_clk, 1));
    end

    always @(negedge clk) begin
        snap_t exp_s, act_s;
        if (q_a.size() > 0) begin
            exp_s = q_a.pop_front();
            act_s = {en_a, h_a, v_a, hsync_a, vsync_a, hs_n_a, vs_n_a};
            checks++;
            if (act_s !== exp_s) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL scoreboard_div2 t=%0t actual=%h required=%h", $time, act_s, exp_s);
            end
        end
        if (q_b.size() > 0) begin
            exp_s = q_b.pop_front();
            act_s = {en_b, h_b, v_b, hsync_b, vsync_b, hs_n_b, vs_n_b};
            checks++;
            if (act_s !== exp_s) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL scoreboard_div1 t=%0t actual=%h required=%h", $time, act_s, exp_s);
            end
        end
    end

    task automatic test_reset();
        res = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({en_a, h_a, v_a, hsync_a, vsync_a, hs_n_a, vs_n_a} !== {1'b0, 11'h760, 11'd0, 4'b0011}) begin
            errors++;
            $display("FAIL reset_state h=%h v=%h en=%b hs=%b vs=%b hs_n=%b vs_n=%b required h=760 v=0 en=0 hs=0 vs=0 hs_n=1 vs_n=1",
                     h_a, v_a, en_a, hsync_a, vsync_a, hs_n_a, vs_n_a);
        end
        res = 1'b1;
        @(negedge clk);
        checks++;
        if (h_a !== 11'h760 || hsync_a !== 1'b0) begin
            errors++;
            $display("FAIL first_clk_hold h=%h hsync=%b required h=760 hsync=0", h_a, hsync_a);
        end
        checks++;
        if (h_b !== 11'h761) begin
            errors++;
            $display("FAIL div1_first_tick h=%h required 761", h_b);
        end
        @(negedge clk);
        checks++;
        if (h_a !== 11'h761 || v_a !== 11'd0) begin
            errors++;
            $display("FAIL first_tick_2clk h=%h v=%h required h=761 v=0", h_a, v_a);
        end
    endtask

    task automatic test_line();
        int  pulses = 0, last_en = -1, period = -1;
        logic spacing_bad = 1'b0, inactive_en = 1'b0, found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (hsync_a) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL line_hsync_timeout actual=none required=strobe"); end
        for (int c = 1; c <= 1700; c++) begin
            @(negedge clk);
            if (en_a) begin
                pulses++;
                if (last_en >= 0 && c - last_en != 2) spacing_bad = 1'b1;
                if (h_a[10]) inactive_en = 1'b1;
                last_en = c;
            end
            if (hsync_a) begin period = c; break; end
        end
        checks++;
        if (pulses != 640) begin errors++; $display("FAIL line_pulses actual=%0d required=640", pulses); end
        checks++;
        if (spacing_bad) begin errors++; $display("FAIL line_spacing actual=irregular required=2clk"); end
        checks++;
        if (inactive_en) begin errors++; $display("FAIL line_enable_blank actual=enable_in_blank required=none"); end
        checks++;
        if (period != 1600) begin errors++; $display("FAIL hsync_period actual=%0d required=1600", period); end
    endtask

    task automatic test_hsync();
        logic prev, found = 1'b0;
        int   low = 0;
        prev = hs_n_a;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (prev && !hs_n_a) begin found = 1'b1; break; end
            prev = hs_n_a;
        end
        checks++;
        if (!found || h_a !== 11'(-144)) begin
            errors++;
            $display("FAIL hs_fall_pos actual=%h required=%h", h_a, 11'(-144));
        end
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            low++;
            @(negedge clk);
            if (hs_n_a) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || h_a !== 11'(-48)) begin
            errors++;
            $display("FAIL hs_rise_pos actual=%h required=%h", h_a, 11'(-48));
        end
        checks++;
        if (low != 192) begin errors++; $display("FAIL hs_width actual=%0d clks required=192", low); end
    endtask

    task automatic test_frame();
        logic prev, found = 1'b0, inv_bad = 1'b0, blank_en = 1'b0;
        int   low = 0;
        prev = vs_n_a;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (en_a && v_a >= 11'(VA)) blank_en = 1'b1;
            if (prev && !vs_n_a) begin found = 1'b1; break; end
            prev = vs_n_a;
        end
        checks++;
        if (!found || v_a !== 11'(VA + VF) || h_a !== 11'h760) begin
            errors++;
            $display("FAIL vs_fall_pos actual=(%h,%0d) required=(760,%0d)", h_a, v_a, VA + VF);
        end
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (vsync_a !== !vs_n_a) inv_bad = 1'b1;
            if (en_a) blank_en = 1'b1;
            low++;
            @(negedge clk);
            if (vs_n_a) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || low != 3200) begin errors++; $display("FAIL vs_width actual=%0d clks required=3200", low); end
        checks++;
        if (inv_bad) begin errors++; $display("FAIL vsync_inverse actual=mismatched required=inverse"); end
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (en_a && v_a >= 11'(VA)) blank_en = 1'b1;
            if (h_a == 11'd639 && v_a == 11'(VT - 1)) begin found = 1'b1; break; end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (h_a != 11'd639) break;
        end
        checks++;
        if (!found || h_a !== 11'h760 || v_a !== 11'd0 || hsync_a !== 1'b1) begin
            errors++;
            $display("FAIL frame_wrap actual=(%h,%0d,hs=%b) required=(760,0,hs=1)", h_a, v_a, hsync_a);
        end
        checks++;
        if (blank_en) begin errors++; $display("FAIL vblank_enable actual=enable required=none"); end
    endtask

    task automatic test_mid_reset();
        logic found = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (h_a == 11'd300 && v_a == 11'd2 && en_a) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_reset_reach actual=none required=(300,2)"); end
        res = 1'b0;
        @(negedge clk);
        checks++;
        if ({en_a, h_a, v_a, hsync_a, vsync_a, hs_n_a, vs_n_a} !== {1'b0, 11'h760, 11'd0, 4'b0011}) begin
            errors++;
            $display("FAIL mid_reset_state h=%h v=%h en=%b required h=760 v=0 en=0", h_a, v_a, en_a);
        end
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (h_a !== 11'h761 || v_a !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_restart h=%h v=%h required h=761 v=0", h_a, v_a);
        end
    endtask

    task automatic test_div1();
        int   period = -1, run = 0, runs = 0;
        logic found = 1'b0, run_bad = 1'b0;
        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            if (hsync_b && v_b == 11'd0) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL div1_frame_start actual=none required=strobe"); end
        for (int c = 1; c <= 9000; c++) begin
            @(negedge clk);
            if (en_b) run++;
            else if (run > 0) begin
                if (run != 640) run_bad = 1'b1;
                runs++;
                run = 0;
            end
            if (hsync_b && v_b == 11'd0) begin period = c; break; end
        end
        checks++;
        if (run_bad || runs != VA) begin
            errors++;
            $display("FAIL div1_runs actual=%0d runs ok=%b required=%0d runs of 640", runs, !run_bad, VA);
        end
        checks++;
        if (period != 800 * VT) begin errors++; $display("FAIL div1_frame_len actual=%0d required=%0d", period, 800 * VT); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_hsync();
        test_frame();
        test_mid_reset();
        test_div1();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
